// File: rtl/mem_stage_if.sv
// Data-cache request/response bundle between the load/store stage and the dcache.
// The master side issues word-aligned requests and holds them until data_valid.
interface mem_stage_if #(
  parameter int XLEN   = 64,
  parameter int STRB_W = 8
);
  logic              req;
  logic              we;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic [STRB_W-1:0] wstrb;
  logic              data_valid;
  logic [XLEN-1:0]   data;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  data_valid, data
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output data_valid, data
  );
endinterface

// File: rtl/mem_stage.sv
// Load/store pipeline stage: captures EX results, performs dcache accesses
// through a req/valid handshake, stalls EX while an access is outstanding,
// forwards results back to EX and hands a registered result to WB.
module mem_stage #(
  parameter int XLEN   = 64,
  parameter int STRB_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              wreg_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [11:0]       csr_waddr_i,
  input  logic              csr_wreg_i,
  input  logic [XLEN-1:0]   csr_wdata_i,
  output logic              stall_o,
  mem_stage_if.master       dcache,
  output logic [4:0]        mem_back_rd_addr_o,
  output logic              mem_back_wreg_o,
  output logic [XLEN-1:0]   mem_back_wdata_o,
  output logic [11:0]       mem_back_csr_waddr_o,
  output logic              mem_back_csr_wreg_o,
  output logic [XLEN-1:0]   mem_back_csr_wdata_o,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_addr_o,
  output logic              wb_wreg_o,
  output logic [XLEN-1:0]   wb_wdata_o,
  output logic [11:0]       wb_csr_waddr_o,
  output logic              wb_csr_wreg_o,
  output logic [XLEN-1:0]   wb_csr_wdata_o,
  output logic              mem_exc_o,
  output logic [XLEN-1:0]   mem_exc_addr_o
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Byte-enable pattern for an access size, before lane shifting.
  function automatic logic [STRB_W-1:0] size_mask(input logic [1:0] sz);
    logic [STRB_W-1:0] m;
    case (sz)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Natural-alignment check for an access size at a byte offset.
  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
    logic m;
    case (sz)
      2'b00:   m = 1'b0;
      2'b01:   m = off[0];
      2'b10:   m = |off[1:0];
      default: m = |off;
    endcase
    return m;
  endfunction

  // Select the addressed lane from the doubleword and sign/zero-extend it.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] data,
                                                  input logic [2:0] off,
                                                  input logic [2:0] f3);
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] res;
    lane = data >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{56{lane[7]}}, lane[7:0]};
      3'b001:  res = {{48{lane[15]}}, lane[15:0]};
      3'b010:  res = {{32{lane[31]}}, lane[31:0]};
      3'b011:  res = lane;
      3'b100:  res = {56'h0, lane[7:0]};
      3'b101:  res = {48'h0, lane[15:0]};
      3'b110:  res = {32'h0, lane[31:0]};
      default: res = {XLEN{1'b0}};
    endcase
    return res;
  endfunction

  // Stage registers
  state_t            state_r;
  logic              valid_r;
  logic              is_load_r;
  logic              is_store_r;
  logic [2:0]        funct3_r;
  logic [4:0]        rd_addr_r;
  logic              wreg_r;
  logic [XLEN-1:0]   wdata_r;
  logic [11:0]       csr_waddr_r;
  logic              csr_wreg_r;
  logic [XLEN-1:0]   csr_wdata_r;
  logic              exc_r;
  logic [XLEN-1:0]   dc_wdata_r;
  logic [STRB_W-1:0] dc_wstrb_r;
  logic [XLEN-1:0]   ld_data_r;

  // Decode of the incoming EX op
  logic              is_load_s;
  logic              is_store_s;
  logic              is_mem_s;
  logic              exc_s;
  logic [STRB_W-1:0] wstrb_s;
  logic [XLEN-1:0]   st_wdata_s;
  logic              stall_s;
  logic              fwd_wreg_s;
  logic              fwd_csr_wreg_s;
  logic [XLEN-1:0]   fwd_wdata_s;

  // Classify the op presented by EX and prepare its dcache lanes.
  always_comb begin
    is_load_s  = ex_valid_i && (opcode_i == OP_LOAD);
    is_store_s = ex_valid_i && (opcode_i == OP_STORE);
    is_mem_s   = is_load_s || is_store_s;
    exc_s      = 1'b0;
    wstrb_s    = {STRB_W{1'b0}};
    st_wdata_s = {XLEN{1'b0}};
    if (is_mem_s) begin
      exc_s = (is_load_s && (funct3_i == 3'b111)) ||
              (is_store_s && funct3_i[2]) ||
              misaligned(funct3_i[1:0], wdata_i[2:0]);
    end else begin
      exc_s = 1'b0;
    end
    if (is_store_s) begin
      wstrb_s    = size_mask(funct3_i[1:0]) << wdata_i[2:0];
      st_wdata_s = store_data_i << {wdata_i[2:0], 3'b000};
    end else begin
      wstrb_s    = {STRB_W{1'b0}};
      st_wdata_s = {XLEN{1'b0}};
    end
  end

  // Stage capture and access FSM; the stage is frozen only while a request is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      valid_r     <= 1'b0;
      is_load_r   <= 1'b0;
      is_store_r  <= 1'b0;
      funct3_r    <= 3'b000;
      rd_addr_r   <= 5'd0;
      wreg_r      <= 1'b0;
      wdata_r     <= {XLEN{1'b0}};
      csr_waddr_r <= 12'd0;
      csr_wreg_r  <= 1'b0;
      csr_wdata_r <= {XLEN{1'b0}};
      exc_r       <= 1'b0;
      dc_wdata_r  <= {XLEN{1'b0}};
      dc_wstrb_r  <= {STRB_W{1'b0}};
      ld_data_r   <= {XLEN{1'b0}};
    end else if (state_r != ST_REQ) begin
      valid_r     <= ex_valid_i;
      is_load_r   <= is_load_s;
      is_store_r  <= is_store_s;
      funct3_r    <= funct3_i;
      rd_addr_r   <= rd_addr_i;
      wreg_r      <= ex_valid_i && wreg_i && !is_store_s;
      wdata_r     <= wdata_i;
      csr_waddr_r <= csr_waddr_i;
      csr_wreg_r  <= ex_valid_i && csr_wreg_i;
      csr_wdata_r <= csr_wdata_i;
      exc_r       <= exc_s;
      dc_wdata_r  <= st_wdata_s;
      dc_wstrb_r  <= wstrb_s;
      if (exc_s) begin
        state_r <= ST_DONE;
      end else if (is_mem_s) begin
        state_r <= ST_REQ;
      end else begin
        state_r <= ST_IDLE;
      end
    end else if (dcache.data_valid) begin
      ld_data_r <= load_extend(dcache.data, wdata_r[2:0], funct3_r);
      state_r   <= ST_DONE;
    end else begin
      state_r <= ST_REQ;
    end
  end

  // Forwarding view of the stage; load results are only usable once the data is back.
  always_comb begin
    stall_s        = (state_r == ST_REQ);
    fwd_wreg_s     = valid_r && wreg_r && !exc_r && (!is_load_r || (state_r == ST_DONE));
    fwd_csr_wreg_s = valid_r && csr_wreg_r && !exc_r;
    if (is_load_r) begin
      fwd_wdata_s = ld_data_r;
    end else begin
      fwd_wdata_s = wdata_r;
    end
  end

  // WB hand-off register; a stalled cycle sends a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_o     <= 1'b0;
      wb_rd_addr_o   <= 5'd0;
      wb_wreg_o      <= 1'b0;
      wb_wdata_o     <= {XLEN{1'b0}};
      wb_csr_waddr_o <= 12'd0;
      wb_csr_wreg_o  <= 1'b0;
      wb_csr_wdata_o <= {XLEN{1'b0}};
    end else if (stall_s) begin
      wb_valid_o    <= 1'b0;
      wb_wreg_o     <= 1'b0;
      wb_csr_wreg_o <= 1'b0;
    end else begin
      wb_valid_o     <= valid_r;
      wb_rd_addr_o   <= rd_addr_r;
      wb_wreg_o      <= fwd_wreg_s;
      wb_wdata_o     <= fwd_wdata_s;
      wb_csr_waddr_o <= csr_waddr_r;
      wb_csr_wreg_o  <= fwd_csr_wreg_s;
      wb_csr_wdata_o <= csr_wdata_r;
    end
  end

  assign stall_o              = stall_s;
  assign dcache.req           = stall_s;
  assign dcache.we            = is_store_r;
  assign dcache.addr          = {wdata_r[XLEN-1:3], 3'b000};
  assign dcache.wdata         = dc_wdata_r;
  assign dcache.wstrb         = dc_wstrb_r;
  assign mem_back_rd_addr_o   = rd_addr_r;
  assign mem_back_wreg_o      = fwd_wreg_s;
  assign mem_back_wdata_o     = fwd_wdata_s;
  assign mem_back_csr_waddr_o = csr_waddr_r;
  assign mem_back_csr_wreg_o  = fwd_csr_wreg_s;
  assign mem_back_csr_wdata_o = csr_wdata_r;
  assign mem_exc_o            = exc_r && (state_r == ST_DONE);
  assign mem_exc_addr_o       = wdata_r;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads with extension,
// stores with lane placement, misaligned/illegal access, back-to-back loads
// and reset during an outstanding request.
module tb_mem_stage;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_addr_i;
  logic        wreg_i;
  logic [63:0] wdata_i;
  logic [63:0] store_data_i;
  logic [11:0] csr_waddr_i;
  logic        csr_wreg_i;
  logic [63:0] csr_wdata_i;
  logic        stall_o;
  logic [4:0]  mem_back_rd_addr_o;
  logic        mem_back_wreg_o;
  logic [63:0] mem_back_wdata_o;
  logic [11:0] mem_back_csr_waddr_o;
  logic        mem_back_csr_wreg_o;
  logic [63:0] mem_back_csr_wdata_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_addr_o;
  logic        wb_wreg_o;
  logic [63:0] wb_wdata_o;
  logic [11:0] wb_csr_waddr_o;
  logic        wb_csr_wreg_o;
  logic [63:0] wb_csr_wdata_o;
  logic        mem_exc_o;
  logic [63:0] mem_exc_addr_o;

  mem_stage_if #(.XLEN(64), .STRB_W(8)) dc ();

  mem_stage #(.XLEN(64), .STRB_W(8)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ex_valid_i           (ex_valid_i),
    .opcode_i             (opcode_i),
    .funct3_i             (funct3_i),
    .rd_addr_i            (rd_addr_i),
    .wreg_i               (wreg_i),
    .wdata_i              (wdata_i),
    .store_data_i         (store_data_i),
    .csr_waddr_i          (csr_waddr_i),
    .csr_wreg_i           (csr_wreg_i),
    .csr_wdata_i          (csr_wdata_i),
    .stall_o              (stall_o),
    .dcache               (dc),
    .mem_back_rd_addr_o   (mem_back_rd_addr_o),
    .mem_back_wreg_o      (mem_back_wreg_o),
    .mem_back_wdata_o     (mem_back_wdata_o),
    .mem_back_csr_waddr_o (mem_back_csr_waddr_o),
    .mem_back_csr_wreg_o  (mem_back_csr_wreg_o),
    .mem_back_csr_wdata_o (mem_back_csr_wdata_o),
    .wb_valid_o           (wb_valid_o),
    .wb_rd_addr_o         (wb_rd_addr_o),
    .wb_wreg_o            (wb_wreg_o),
    .wb_wdata_o           (wb_wdata_o),
    .wb_csr_waddr_o       (wb_csr_waddr_o),
    .wb_csr_wreg_o        (wb_csr_wreg_o),
    .wb_csr_wdata_o       (wb_csr_wdata_o),
    .mem_exc_o            (mem_exc_o),
    .mem_exc_addr_o       (mem_exc_addr_o)
  );

  // Free-running clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Request-phase snapshot taken in the first REQ cycle of an access
  logic [63:0] r_addr;
  logic [7:0]  r_wstrb;
  logic [63:0] r_wdata;
  logic        r_we;
  logic        r_stable;
  int          r_stalls;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one op from EX (caller is just past a negedge), then serve the
  // dcache, raising data_valid in REQ cycle n_req. Returns at the negedge
  // where the op sits in the stage with stall released.
  task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic w, input logic [63:0] addr, input logic [63:0] sd,
                       input logic [63:0] rdata, input int n_req);
    ex_valid_i   = 1'b1;
    opcode_i     = op;
    funct3_i     = f3;
    rd_addr_i    = rd;
    wreg_i       = w;
    wdata_i      = addr;
    store_data_i = sd;
    @(negedge clk);
    ex_valid_i = 1'b0;
    r_stalls   = 0;
    r_stable   = 1'b1;
    while (stall_o && r_stalls < 40) begin
      r_stalls++;
      if (r_stalls == 1) begin
        r_addr  = dc.addr;
        r_wstrb = dc.wstrb;
        r_wdata = dc.wdata;
        r_we    = dc.we;
      end else if (dc.addr !== r_addr || dc.wstrb !== r_wstrb ||
                   dc.wdata !== r_wdata || dc.we !== r_we || dc.req !== 1'b1) begin
        r_stable = 1'b0;
      end
      if (r_stalls == n_req) begin
        dc.data_valid = 1'b1;
        dc.data       = rdata;
      end
      @(negedge clk);
      dc.data_valid = 1'b0;
    end
    check("stall_released", stall_o, 1'b0);
  endtask

  initial begin
    rst           = 1'b1;
    ex_valid_i    = 1'b0;
    opcode_i      = 7'd0;
    funct3_i      = 3'd0;
    rd_addr_i     = 5'd0;
    wreg_i        = 1'b0;
    wdata_i       = 64'd0;
    store_data_i  = 64'd0;
    csr_waddr_i   = 12'd0;
    csr_wreg_i    = 1'b0;
    csr_wdata_i   = 64'd0;
    dc.data_valid = 1'b0;
    dc.data       = 64'd0;
    repeat (2) @(negedge clk);
    check("rst_stall", stall_o, 1'b0);
    check("rst_req", dc.req, 1'b0);
    check("rst_wb_valid", wb_valid_o, 1'b0);
    check("rst_wb_wreg", wb_wreg_o, 1'b0);
    check("rst_wb_wdata", wb_wdata_o, 64'd0);
    check("rst_exc", mem_exc_o, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // ADD to x5 with a CSR write riding along
    csr_waddr_i = 12'h300;
    csr_wreg_i  = 1'b1;
    csr_wdata_i = 64'hABCD;
    do_op(OP_ALU, 3'b000, 5'd5, 1'b1, 64'h1234, 64'd0, 64'd0, 0);
    csr_wreg_i = 1'b0;
    check("add_stalls", r_stalls, 0);
    check("add_fwd_wreg", mem_back_wreg_o, 1'b1);
    check("add_fwd_wdata", mem_back_wdata_o, 64'h1234);
    check("add_fwd_rd", mem_back_rd_addr_o, 5'd5);
    check("add_fwd_csr_wreg", mem_back_csr_wreg_o, 1'b1);
    check("add_fwd_csr_wdata", mem_back_csr_wdata_o, 64'hABCD);
    @(negedge clk);
    check("add_wb_valid", wb_valid_o, 1'b1);
    check("add_wb_wreg", wb_wreg_o, 1'b1);
    check("add_wb_wdata", wb_wdata_o, 64'h1234);
    check("add_wb_csr_waddr", wb_csr_waddr_o, 12'h300);

    // LB at 0x1003, data after three REQ cycles
    do_op(OP_LOAD, 3'b000, 5'd6, 1'b1, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 3);
    check("lb_stalls", r_stalls, 3);
    check("lb_addr", r_addr, 64'h1000);
    check("lb_we", r_we, 1'b0);
    check("lb_wstrb", r_wstrb, 8'h00);
    check("lb_req_stable", r_stable, 1'b1);
    check("lb_fwd_wreg", mem_back_wreg_o, 1'b1);
    check("lb_fwd_wdata", mem_back_wdata_o, 64'hFFFF_FFFF_FFFF_FF80);
    @(negedge clk);
    check("lb_wb_valid", wb_valid_o, 1'b1);
    check("lb_wb_wdata", wb_wdata_o, 64'hFFFF_FFFF_FFFF_FF80);

    // LBU same address
    do_op(OP_LOAD, 3'b100, 5'd6, 1'b1, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 1);
    check("lbu_fwd_wdata", mem_back_wdata_o, 64'h80);
    @(negedge clk);
    check("lbu_wb_wdata", wb_wdata_o, 64'h80);

    // SW at 0x2004
    do_op(OP_STORE, 3'b010, 5'd0, 1'b0, 64'h2004, 64'hDEADBEEF, 64'd0, 2);
    check("sw_stalls", r_stalls, 2);
    check("sw_addr", r_addr, 64'h2000);
    check("sw_wstrb", r_wstrb, 8'hF0);
    check("sw_wdata", r_wdata, 64'hDEADBEEF_0000_0000);
    check("sw_we", r_we, 1'b1);
    check("sw_req_stable", r_stable, 1'b1);
    check("sw_fwd_wreg", mem_back_wreg_o, 1'b0);
    @(negedge clk);
    check("sw_wb_valid", wb_valid_o, 1'b1);
    check("sw_wb_wreg", wb_wreg_o, 1'b0);

    // SB at 0x2007 lands in the top byte lane
    do_op(OP_STORE, 3'b000, 5'd0, 1'b0, 64'h2007, 64'hAB, 64'd0, 1);
    check("sb_wstrb", r_wstrb, 8'h80);
    check("sb_wdata", r_wdata, 64'hAB00_0000_0000_0000);
    @(negedge clk);

    // Misaligned LW: no request, exception in the DONE cycle
    do_op(OP_LOAD, 3'b010, 5'd7, 1'b1, 64'h3002, 64'd0, 64'd0, 1);
    check("lw_mis_stalls", r_stalls, 0);
    check("lw_mis_req", dc.req, 1'b0);
    check("lw_mis_exc", mem_exc_o, 1'b1);
    check("lw_mis_exc_addr", mem_exc_addr_o, 64'h3002);
    check("lw_mis_fwd_wreg", mem_back_wreg_o, 1'b0);
    @(negedge clk);
    check("lw_mis_wb_wreg", wb_wreg_o, 1'b0);
    check("lw_mis_exc_clear", mem_exc_o, 1'b0);

    // Illegal load encoding funct3=111
    do_op(OP_LOAD, 3'b111, 5'd7, 1'b1, 64'h3000, 64'd0, 64'd0, 1);
    check("ld_ill_stalls", r_stalls, 0);
    check("ld_ill_exc", mem_exc_o, 1'b1);
    @(negedge clk);

    // Back-to-back LD, LD with data in the first REQ cycle
    do_op(OP_LOAD, 3'b011, 5'd8, 1'b1, 64'h4000, 64'd0, 64'h1122_3344_5566_7788, 1);
    check("ld1_stalls", r_stalls, 1);
    check("ld1_fwd_wdata", mem_back_wdata_o, 64'h1122_3344_5566_7788);
    do_op(OP_LOAD, 3'b011, 5'd9, 1'b1, 64'h4008, 64'd0, 64'h8877_6655_4433_2211, 1);
    check("ld2_stalls", r_stalls, 1);
    check("ld2_addr", r_addr, 64'h4008);
    check("ld2_fwd_wdata", mem_back_wdata_o, 64'h8877_6655_4433_2211);
    check("ld2_fwd_rd", mem_back_rd_addr_o, 5'd9);
    @(negedge clk);
    check("ld2_wb_wdata", wb_wdata_o, 64'h8877_6655_4433_2211);

    // Reset during REQ, then a stray data_valid
    ex_valid_i = 1'b1;
    opcode_i   = OP_LOAD;
    funct3_i   = 3'b011;
    rd_addr_i  = 5'd10;
    wreg_i     = 1'b1;
    wdata_i    = 64'h5000;
    @(negedge clk);
    ex_valid_i = 1'b0;
    check("rstreq_req_before", dc.req, 1'b1);
    rst = 1'b1;
    #1;
    check("rstreq_req_drop", dc.req, 1'b0);
    check("rstreq_stall_drop", stall_o, 1'b0);
    @(negedge clk);
    rst           = 1'b0;
    dc.data_valid = 1'b1;
    dc.data       = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    dc.data_valid = 1'b0;
    check("stray_stall", stall_o, 1'b0);
    check("stray_fwd_wreg", mem_back_wreg_o, 1'b0);
    check("stray_exc", mem_exc_o, 1'b0);
    @(negedge clk);
    check("stray_wb_valid", wb_valid_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
